beep_scheduler: RTL

BEEP_SCHEDULER -- requirements
Module: beep_scheduler

---
 rtl/beep_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/beep_scheduler.sv
// Buzzer pattern scheduler: latches event requests, arbitrates 2 > 1 > 0, plays 1/2/4 beep pulses then a gap.
// Optional compile-time macro BEEP_PREEMPT_EN lets a higher-priority request abort a pattern during OFF or GAP.
module beep_scheduler #(
    parameter int unsigned TICK_DIV  = 2500000,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 2,
    parameter int unsigned GAP_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic       beep,
    output logic       busy,
    output logic [2:0] grant,
    output logic [1:0] active_id
);

    localparam int unsigned PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_A     = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
    localparam int unsigned TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [PRESC_W-1:0]   presc, presc_n;
    logic [TICK_W-1:0]    ticks, ticks_n;
    logic [2:0]           pulses, pulses_n;
    logic [2:0]           pending, pending_n;
    logic                 beep_n, busy_n;
    logic [2:0]           grant_n;
    logic [1:0]           active_n;
    logic [1:0]           win_c;
    logic [2:0]           clr_c;
    logic                 start_c;
    logic                 tick_c;

    assign tick_c = (presc == PRESC_W'(TICK_DIV - 1));

    // Fixed priority: highest index wins
    always_comb begin
        if (pending[2])      win_c = 2'd2;
        else if (pending[1]) win_c = 2'd1;
        else                 win_c = 2'd0;
    end

`ifdef BEEP_PREEMPT_EN
    logic [2:0] above_c;

    // Requesters strictly above the active one
    always_comb begin
        case (active_id)
            2'd0:    above_c = 3'b110;
            2'd1:    above_c = 3'b100;
            default: above_c = 3'b000;
        endcase
    end
`endif

    always_comb begin
        state_n  = state;
        presc_n  = tick_c ? '0 : presc + PRESC_W'(1);
        ticks_n  = tick_c ? ticks + TICK_W'(1) : ticks;
        pulses_n = pulses;
        active_n = active_id;
        grant_n  = '0;
        clr_c    = '0;
        start_c  = 1'b0;

        case (state)
            IDLE: begin
                presc_n = '0;
                ticks_n = '0;
                if (|pending) start_c = 1'b1;
            end
            ON: begin
                if (tick_c && ticks == TICK_W'(ON_TICKS - 1)) begin
                    state_n  = (pulses <= 3'd1) ? GAP : OFF;
                    pulses_n = pulses - 3'd1;
                end
            end
            OFF: begin
                if (tick_c && ticks == TICK_W'(OFF_TICKS - 1)) state_n = ON;
            end
            GAP: begin
                if (tick_c && ticks == TICK_W'(GAP_TICKS - 1)) begin
                    state_n  = IDLE;
                    active_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef BEEP_PREEMPT_EN
        if ((state == OFF || state == GAP) && |(pending & above_c)) start_c = 1'b1;
`endif

        if (start_c) begin
            state_n  = ON;
            grant_n  = 3'b001 << win_c;
            clr_c    = grant_n;
            active_n = win_c;
            case (win_c)
                2'd2:    pulses_n = 3'd4;
                2'd1:    pulses_n = 3'd2;
                default: pulses_n = 3'd1;
            endcase
        end

        // Every state change restarts the prescaler and tick counter
        if (state_n != state || start_c) begin
            presc_n = '0;
            ticks_n = '0;
        end

        // A request arriving with the grant keeps its bit pending
        pending_n = (pending & ~clr_c) | req;
        beep_n    = (state_n == ON);
        busy_n    = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            ticks     <= '0;
            pulses    <= '0;
            pending   <= '0;
            beep      <= 1'b0;
            busy      <= 1'b0;
            grant     <= '0;
            active_id <= '0;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            ticks     <= ticks_n;
            pulses    <= pulses_n;
            pending   <= pending_n;
            beep      <= beep_n;
            busy      <= busy_n;
            grant     <= grant_n;
            active_id <= active_n;
        end
    end

endmodule
